// File: rtl/core_lsu_initiator.sv
// LSU initiator: converts execute-stage load/store ops into memory-arbiter
// transactions, with lane steering, load extension and fault reporting.
module core_lsu_initiator #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clk_en,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [2:0]    i_req_funct3,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  output logic [DW-1:0] o_rsp_data,
  output logic          o_rsp_fault,
  output logic [1:0]    o_rsp_cause,
  output logic          o_lsu_read,
  output logic [AW-1:0] o_r_lsu_addr,
  input  logic [DW-1:0] i_r_lsu_data,
  input  logic          i_lsu_ack,
  output logic          o_lsu_write,
  output logic [AW-1:0] o_w_lsu_addr,
  output logic [3:0]    o_w_lsu_byte_en,
  output logic [DW-1:0] o_w_lsu_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] CAUSE_OK       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  localparam int              CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    funct3_q;
  logic [1:0]    ofs_q;

  logic          illegal;
  logic          misaligned;
  logic [3:0]    be_nxt;
  logic [DW-1:0] wd_nxt;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [DW-1:0] ld_ext;

  // Request decode. Stores only accept B/H/W; the unsigned variants are load-only.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    be_nxt     = 4'b0000;
    wd_nxt     = i_req_wdata;
    case (i_req_funct3)
      3'b000: begin
        be_nxt = 4'b0001 << i_req_addr[1:0];
        wd_nxt = {4{i_req_wdata[7:0]}};
      end
      3'b001: begin
        be_nxt     = 4'b0011 << i_req_addr[1:0];
        wd_nxt     = {2{i_req_wdata[15:0]}};
        misaligned = i_req_addr[0];
      end
      3'b010: begin
        be_nxt     = 4'b1111;
        misaligned = |i_req_addr[1:0];
      end
      3'b100: illegal = i_req_we;
      3'b101: begin
        illegal    = i_req_we;
        misaligned = i_req_addr[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  // Load lane select and extension, driven by the offset/size captured at accept.
  always_comb begin
    lane_b = i_r_lsu_data[{ofs_q, 3'b000} +: 8];
    lane_h = ofs_q[1] ? i_r_lsu_data[31:16] : i_r_lsu_data[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  ld_ext = {24'b0, lane_b};
      3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  ld_ext = {16'b0, lane_h};
      default: ld_ext = i_r_lsu_data;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      funct3_q        <= 3'b000;
      ofs_q           <= 2'b00;
      o_req_ready     <= 1'b1;
      o_rsp_valid     <= 1'b0;
      o_rsp_data      <= '0;
      o_rsp_fault     <= 1'b0;
      o_rsp_cause     <= CAUSE_OK;
      o_lsu_read      <= 1'b0;
      o_r_lsu_addr    <= '0;
      o_lsu_write     <= 1'b0;
      o_w_lsu_addr    <= '0;
      o_w_lsu_byte_en <= 4'b0000;
      o_w_lsu_data    <= '0;
    end else if (i_clk_en) begin
      case (state)
        S_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            o_req_ready <= 1'b0;
            funct3_q    <= i_req_funct3;
            ofs_q       <= i_req_addr[1:0];
            if (illegal || misaligned) begin
              state       <= S_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_fault <= 1'b1;
              o_rsp_cause <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
              o_rsp_data  <= '0;
            end else if (i_req_we) begin
              state           <= S_WRITE;
              o_lsu_write     <= 1'b1;
              o_w_lsu_addr    <= {i_req_addr[AW-1:2], 2'b00};
              o_w_lsu_byte_en <= be_nxt;
              o_w_lsu_data    <= wd_nxt;
            end else begin
              state        <= S_READ;
              o_lsu_read   <= 1'b1;
              o_r_lsu_addr <= {i_req_addr[AW-1:2], 2'b00};
              cnt          <= '0;
            end
          end
        end
        S_WRITE: begin
          state       <= S_RESP;
          o_lsu_write <= 1'b0;
          o_rsp_valid <= 1'b1;
          o_rsp_fault <= 1'b0;
          o_rsp_cause <= CAUSE_OK;
          o_rsp_data  <= '0;
        end
        S_READ: begin
          // An ack in the final allowed cycle beats the timeout.
          if (i_lsu_ack) begin
            state       <= S_RESP;
            o_lsu_read  <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_fault <= 1'b0;
            o_rsp_cause <= CAUSE_OK;
            o_rsp_data  <= ld_ext;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
            state       <= S_RESP;
            o_lsu_read  <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_fault <= 1'b1;
            o_rsp_cause <= CAUSE_TIMEOUT;
            o_rsp_data  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state       <= S_IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_rsp_fault <= 1'b0;
          o_rsp_cause <= CAUSE_OK;
          o_rsp_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_lsu_initiator.sv
// Self-checking bench for core_lsu_initiator: directed vector table, hand-written
// corner sequences, and randomized ops against a behavioural reference model.
module tb_core_lsu_initiator;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic [1:0]  rsp_cause;
  logic        lsu_read;
  logic [31:0] r_lsu_addr;
  logic [31:0] r_lsu_data;
  logic        lsu_ack;
  logic        lsu_write;
  logic [31:0] w_lsu_addr;
  logic [3:0]  w_lsu_byte_en;
  logic [31:0] w_lsu_data;

  always #5 clk = ~clk;

  core_lsu_initiator #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_fault(rsp_fault),
    .o_rsp_cause(rsp_cause), .o_lsu_read(lsu_read), .o_r_lsu_addr(r_lsu_addr),
    .i_r_lsu_data(r_lsu_data), .i_lsu_ack(lsu_ack), .o_lsu_write(lsu_write),
    .o_w_lsu_addr(w_lsu_addr), .o_w_lsu_byte_en(w_lsu_byte_en), .o_w_lsu_data(w_lsu_data)
  );

  typedef struct {
    int          lat;     // cycles from accept edge to rsp_valid seen
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] data;
    int          reads;   // cycles with o_lsu_read high
    int          writes;  // cycles with o_lsu_write high
    logic [31:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] raddr;
  } res_t;

  typedef struct {
    bit          we;
    bit [2:0]    f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          d;       // ack delay in READ cycles; >= TO means never
    res_t        exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t r(input int lat, input logic fault, input logic [1:0] cause,
                             input logic [31:0] data, input int reads, input int writes,
                             input logic [31:0] waddr, input logic [3:0] be,
                             input logic [31:0] wdata, input logic [31:0] raddr);
    res_t x;
    x.lat = lat; x.fault = fault; x.cause = cause; x.data = data; x.reads = reads;
    x.writes = writes; x.waddr = waddr; x.be = be; x.wdata = wdata; x.raddr = raddr;
    return x;
  endfunction

  function automatic vec_t mkv(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int d, input res_t e);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.d = d; v.exp = e;
    return v;
  endfunction

  // Reference model: outcome of one op derived from the access rules directly.
  function automatic res_t model(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int d);
    res_t        e;
    int          a;
    int          size;
    int          shift;
    bit          illegal;
    bit          mis;
    logic [31:0] mask;
    logic [31:0] val;
    e = r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    a = int'(addr & 32'h3);
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    mis = ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) || (f3 == 3'd2 && a != 0);
    if (illegal || mis) begin
      e.lat = 1; e.fault = 1'b1; e.cause = illegal ? 2'd3 : 2'd1;
    end else if (we) begin
      e.lat = 2; e.writes = 1; e.waddr = addr - 32'(a);
      if (f3 == 3'd0) begin
        e.be = 4'(1 << a); e.wdata = (wdata & 32'hFF) * 32'h01010101;
      end else if (f3 == 3'd1) begin
        e.be = 4'(3 << a); e.wdata = (wdata & 32'hFFFF) * 32'h00010001;
      end else begin
        e.be = 4'hF; e.wdata = wdata;
      end
    end else begin
      e.raddr = addr - 32'(a);
      if (d >= TO) begin
        e.lat = TO + 1; e.reads = TO; e.fault = 1'b1; e.cause = 2'd2;
      end else begin
        e.lat = d + 2; e.reads = d + 1;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        shift = (size == 1) ? a : (size == 2) ? (a / 2) * 2 : 0;
        mask  = (size == 4) ? 32'hFFFFFFFF : (32'h1 << (8 * size)) - 32'h1;
        val   = (rdata >> (8 * shift)) & mask;
        if (size < 4 && !f3[2] && val >= (32'h1 << (8 * size - 1))) val = val | ~mask;
        e.data = val;
      end
    end
    return e;
  endfunction

  // Issue one op from IDLE, service the bus, and record what the DUT did.
  task automatic run_op(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int d,
                        output res_t o);
    o = r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    check("ready_busy", 32'(req_ready), 32'd0);
    for (int n = 1; n <= 40; n++) begin
      if (lsu_read)  begin o.reads++;  o.raddr = r_lsu_addr; end
      if (lsu_write) begin
        o.writes++; o.waddr = w_lsu_addr; o.be = w_lsu_byte_en; o.wdata = w_lsu_data;
      end
      if (rsp_valid) begin
        o.lat = n; o.fault = rsp_fault; o.cause = rsp_cause; o.data = rsp_data;
        break;
      end
      lsu_ack    = (n >= d + 1);
      r_lsu_data = rdata;
      tick();
    end
    lsu_ack = 1'b0;
    tick();
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
  endtask

  task automatic cmp(input string tag, input res_t o, input res_t e);
    check({tag, "_lat"},    32'(o.lat),    32'(e.lat));
    check({tag, "_fault"},  32'(o.fault),  32'(e.fault));
    check({tag, "_cause"},  32'(o.cause),  32'(e.cause));
    check({tag, "_data"},   o.data,        e.data);
    check({tag, "_reads"},  32'(o.reads),  32'(e.reads));
    check({tag, "_writes"}, 32'(o.writes), 32'(e.writes));
    check({tag, "_waddr"},  o.waddr,       e.waddr);
    check({tag, "_be"},     32'(o.be),     32'(e.be));
    check({tag, "_wdata"},  o.wdata,       e.wdata);
    check({tag, "_raddr"},  o.raddr,       e.raddr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    res_t o;
    res_t e;
    int   k;
    int   cnt_rsp;
    int   cnt_rd;

    rst = 1'b1; clk_en = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; r_lsu_data = '0; lsu_ack = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_lsu_read", 32'(lsu_read), 32'd0);
    check("rst_lsu_write", 32'(lsu_write), 32'd0);
    check("rst_byte_en", 32'(w_lsu_byte_en), 32'd0);
    rst = 1'b0;
    tick();

    // Directed vectors with hand-derived expectations.
    tbl.push_back(mkv(1, 3'd0, 32'h1003, 32'hAB, 0, 0, r(2, 0, 0, 0, 0, 1, 32'h1000, 4'b1000, 32'hABABABAB, 0)));
    tbl.push_back(mkv(0, 3'd1, 32'h0102, 0, 32'h80011234, 3, r(5, 0, 0, 32'hFFFF8001, 4, 0, 0, 0, 0, 32'h100)));
    tbl.push_back(mkv(0, 3'd5, 32'h0102, 0, 32'h80011234, 3, r(5, 0, 0, 32'h00008001, 4, 0, 0, 0, 0, 32'h100)));
    tbl.push_back(mkv(0, 3'd2, 32'h0006, 0, 0, 0, r(1, 1, 1, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv(1, 3'd5, 32'h0010, 32'h1234, 0, 0, r(1, 1, 3, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv(0, 3'd2, 32'h0020, 0, 32'h55, 100, r(9, 1, 2, 0, 8, 0, 0, 0, 0, 32'h20)));
    tbl.push_back(mkv(0, 3'd2, 32'h0024, 0, 32'hDEADBEEF, 7, r(9, 0, 0, 32'hDEADBEEF, 8, 0, 0, 0, 0, 32'h24)));
    tbl.push_back(mkv(1, 3'd2, 32'h0044, 32'h12345678, 0, 0, r(2, 0, 0, 0, 0, 1, 32'h44, 4'hF, 32'h12345678, 0)));
    tbl.push_back(mkv(0, 3'd0, 32'h0201, 0, 32'h00008000, 0, r(2, 0, 0, 32'hFFFFFF80, 1, 0, 0, 0, 0, 32'h200)));
    tbl.push_back(mkv(0, 3'd4, 32'h0203, 0, 32'h7F000000, 1, r(3, 0, 0, 32'h0000007F, 2, 0, 0, 0, 0, 32'h200)));
    tbl.push_back(mkv(1, 3'd1, 32'h0302, 32'hCAFEBEEF, 0, 0, r(2, 0, 0, 0, 0, 1, 32'h300, 4'b1100, 32'hBEEFBEEF, 0)));
    tbl.push_back(mkv(1, 3'd5, 32'h0011, 0, 0, 0, r(1, 1, 3, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv(1, 3'd1, 32'h0001, 0, 0, 0, r(1, 1, 1, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv(0, 3'd6, 32'h0003, 0, 0, 0, r(1, 1, 3, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv(0, 3'd1, 32'h0100, 0, 32'h0000ABCD, 2, r(4, 0, 0, 32'hFFFFABCD, 3, 0, 0, 0, 0, 32'h100)));
    foreach (tbl[i]) begin
      run_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].d, o);
      cmp($sformatf("vec%0d", i), o, tbl[i].exp);
    end

    // Clock enable low for 4 cycles mid-READ with ack held: no progress.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
    tick();
    req_valid = 1'b0; clk_en = 1'b0; lsu_ack = 1'b1; r_lsu_data = 32'h13572468;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("freeze_read", 32'(lsu_read), 32'd1);
      check("freeze_rsp", 32'(rsp_valid), 32'd0);
    end
    clk_en = 1'b1;
    tick();
    lsu_ack = 1'b0;
    check("freeze_done_valid", 32'(rsp_valid), 32'd1);
    check("freeze_done_data", rsp_data, 32'h13572468);
    check("freeze_done_cause", 32'(rsp_cause), 32'd0);
    tick();

    // Timeout counter must hold while the clock enable is low.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    clk_en = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rsp_valid) begin k = i; break; end
    end
    check("freeze_timeout_cycles", 32'(k), 32'd5);
    check("freeze_timeout_cause", 32'(rsp_cause), 32'd2);
    tick();

    // Reset during READ abandons the transaction; later stray acks are ignored.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'hC0;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_read", 32'(lsu_read), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    cnt_rsp = 0; cnt_rd = 0;
    lsu_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid) cnt_rsp++;
      if (lsu_read)  cnt_rd++;
    end
    lsu_ack = 1'b0;
    check("stray_ack_rsp", 32'(cnt_rsp), 32'd0);
    check("stray_ack_read", 32'(cnt_rd), 32'd0);
    check("stray_ack_ready", 32'(req_ready), 32'd1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 300; i++) begin
      bit          we;
      bit [2:0]    f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          d;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      wd   = $urandom;
      rd   = $urandom;
      d    = int'($urandom_range(0, 10));
      e    = model(we, f3, addr, wd, rd, d);
      run_op(we, f3, addr, wd, rd, d, o);
      cmp($sformatf("rnd%0d", i), o, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
